// File: rtl/instr_prefetch_pkg.sv
// Shared constants and PC helpers for the single-cycle MIPS simulator front end.
package instr_prefetch_pkg;

  localparam int unsigned INSTR_NUM = 256;
  localparam int unsigned DATA_NUM  = 256;
  localparam int unsigned WORD_W    = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fifo_entry_t;

  // Word-align a redirect target and fold it into instruction memory.
  function automatic logic [31:0] pc_wrap(input logic [31:0] pc, input int unsigned instr_num);
    logic [31:0] limit;
    limit = instr_num << 2;
    return {pc[31:2], 2'b00} % limit;
  endfunction

  function automatic logic [31:0] pc_inc(input logic [31:0] pc, input int unsigned instr_num);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    return (nxt >= (instr_num << 2)) ? '0 : nxt;
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Instruction memory and core-side handshake bundle for the prefetch stage.
interface instr_prefetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/instr_prefetch_fifo.sv
// Registered {pc,instr} FIFO; head is read straight from storage (no bypass).
module prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fifo_entry_t                push_data_i,
  input  logic                       pop_i,
  output fifo_entry_t                head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: issues word reads ahead of the core, buffers responses,
// and flushes/restarts on redirect while dropping responses already in flight.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INSTR_NUM = instr_prefetch_pkg::INSTR_NUM
) (
  input  logic              clk_i,
  input  logic              rst_i,
  instr_prefetch_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy, outstanding;
  logic          req, resp_live, push, pop, fifo_valid;
  fifo_entry_t   head, push_entry;

  assign occupancy   = {1'b0, count} + {1'b0, inflight_q};
  assign outstanding = {1'b0, discard_q} + {1'b0, inflight_q};
  assign req         = !rst_i && !bus.redirect_i && (occupancy < DEPTH_C);
  // Orphan responses (nothing outstanding) are ignored rather than pushed.
  assign resp_live   = bus.imem_rvalid_i && (discard_q == '0) && (inflight_q != '0);
  assign push        = resp_live && !bus.redirect_i;
  assign pop         = fifo_valid && bus.instr_ready_i && !bus.redirect_i;
  assign push_entry  = '{pc: resp_pc_q, instr: bus.imem_rdata_i};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (bus.redirect_i) begin
      // Every outstanding response becomes stale; one arriving now is dropped here.
      fetch_pc_d = pc_wrap(bus.redirect_pc_i, INSTR_NUM);
      resp_pc_d  = pc_wrap(bus.redirect_pc_i, INSTR_NUM);
      inflight_d = '0;
      if (bus.imem_rvalid_i && (outstanding != '0))
        discard_d = CW'(outstanding - {{CW{1'b0}}, 1'b1});
      else
        discard_d = CW'(outstanding);
    end else begin
      if (req) fetch_pc_d = pc_inc(fetch_pc_q, INSTR_NUM);
      if (bus.imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (resp_live) resp_pc_d = pc_inc(resp_pc_q, INSTR_NUM);
      case ({req, resp_live})
        2'b10:   inflight_d = inflight_q + CW'(1);
        2'b01:   inflight_d = inflight_q - CW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (bus.redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (fifo_valid),
    .count_o     (count)
  );

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = fifo_valid;
  assign bus.instr_o       = head.instr;
  assign bus.instr_pc_o    = head.pc;

  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.imem_rvalid_i && (inflight_q == '0) && (discard_q == '0)));

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized bench for instr_prefetch against a queue-based model of the fetch stream.
module tb_instr_prefetch;
  import instr_prefetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WRAP  = INSTR_NUM * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_prefetch_if bus();

  instr_prefetch #(.DEPTH(DEPTH), .INSTR_NUM(INSTR_NUM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  logic [31:0] imem [INSTR_NUM];
  pend_t       mem_q[$];
  logic [31:0] live_q[$];
  logic [31:0] buf_pc[$];
  int unsigned stale;
  logic [31:0] m_fetch;
  int unsigned cyc = 0;
  int unsigned lat_lo = 1, lat_hi = 1;
  int unsigned n_req_seen;

  function automatic logic resp_now();
    return (mem_q.size() != 0) && (mem_q[0].due <= cyc);
  endfunction

  // One clock: entered just after a falling edge, left at the next falling edge.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic        exp_req, rv, act_req;
    logic [31:0] act_addr;
    int unsigned d;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.instr_ready_i = rdy;
    rv = resp_now();
    bus.imem_rvalid_i = rv;
    if (rv) bus.imem_rdata_i = imem[mem_q[0].addr[9:2]];
    else    bus.imem_rdata_i = $urandom;
    #1;
    exp_req = !redir && ((buf_pc.size() + live_q.size()) < DEPTH);
    check("imem_req_o", 32'(bus.imem_req_o), 32'(exp_req));
    if (exp_req) check("imem_addr_o", bus.imem_addr_o, m_fetch);
    check("instr_valid_o", 32'(bus.instr_valid_o), 32'(buf_pc.size() != 0));
    if (buf_pc.size() != 0) begin
      check("instr_pc_o", bus.instr_pc_o, buf_pc[0]);
      check("instr_o", bus.instr_o, imem[buf_pc[0][9:2]]);
    end
    act_req  = bus.imem_req_o;
    act_addr = bus.imem_addr_o;
    if (act_req) n_req_seen++;
    @(posedge clk);
    if (rv) void'(mem_q.pop_front());
    if (act_req) begin
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (mem_q.size() != 0 && d <= mem_q[$].due) d = mem_q[$].due + 1;
      mem_q.push_back('{addr: act_addr, due: d});
    end
    if (redir) begin
      if (rv) begin
        if (stale != 0) stale--;
        else if (live_q.size() != 0) void'(live_q.pop_front());
      end
      stale += live_q.size();
      live_q.delete();
      buf_pc.delete();
      m_fetch = {rpc[31:2], 2'b00} % WRAP;
    end else begin
      if (rdy && buf_pc.size() != 0) void'(buf_pc.pop_front());
      if (rv) begin
        if (stale != 0) stale--;
        else if (live_q.size() != 0) buf_pc.push_back(live_q.pop_front());
        else check("orphan_response", 32'd1, 32'd0);
      end
      if (exp_req) begin
        live_q.push_back(m_fetch);
        m_fetch = (m_fetch + 4) % WRAP;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.redirect_i    = 1'b0;
    #1;
    check("rst imem_req_o", 32'(bus.imem_req_o), 32'd0);
    check("rst imem_addr_o", bus.imem_addr_o, 32'd0);
    check("rst instr_valid_o", 32'(bus.instr_valid_o), 32'd0);
    check("rst instr_o", bus.instr_o, 32'd0);
    check("rst instr_pc_o", bus.instr_pc_o, 32'd0);
    mem_q.delete();
    live_q.delete();
    buf_pc.delete();
    stale   = 0;
    m_fetch = '0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned guard;
    logic        found;
    for (int unsigned k = 0; k < INSTR_NUM; k++) imem[k] = 32'h1000 + k;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.instr_ready_i = 1'b0;

    do_reset(2);
    repeat (20) step(1'b0, '0, 1'b1);

    // Back-pressure from empty: exactly DEPTH requests, then drain.
    do_reset(1);
    n_req_seen = 0;
    repeat (10) step(1'b0, '0, 1'b0);
    check("hold_req_count", n_req_seen, DEPTH);
    repeat (12) step(1'b0, '0, 1'b1);

    // Latency 3, redirect with three requests outstanding.
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (guard = 0; guard < 20 && !found; guard++) begin
      if (live_q.size() == 3) found = 1'b1;
      else step(1'b0, '0, 1'b1);
    end
    check("l3_inflight_reached", 32'(found), 32'd1);
    step(1'b1, 32'h43, 1'b1);
    repeat (15) step(1'b0, '0, 1'b1);

    // Address wrap at the top of instruction memory.
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 32'h3F0, 1'b1);
    repeat (14) step(1'b0, '0, 1'b1);

    // Redirect in the same cycle as a response and a ready head.
    found = 1'b0;
    for (guard = 0; guard < 20 && !found; guard++) begin
      if (resp_now() && buf_pc.size() != 0) found = 1'b1;
      else step(1'b0, '0, 1'b1);
    end
    check("coincident_found", 32'(found), 32'd1);
    step(1'b1, 32'h100, 1'b1);
    repeat (10) step(1'b0, '0, 1'b1);

    // Fill the FIFO, then reset mid-stream.
    repeat (8) step(1'b0, '0, 1'b0);
    check("full_before_reset", 32'(bus.instr_valid_o), 32'd1);
    do_reset(2);
    repeat (10) step(1'b0, '0, 1'b1);

    // Random traffic.
    lat_lo = 1; lat_hi = 3;
    repeat (400) begin
      logic        r_dir;
      logic [31:0] r_pc;
      r_dir = ($urandom_range(99, 0) < 5);
      r_pc  = $urandom;
      step(r_dir, r_pc, ($urandom_range(3, 0) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
